// File: rtl/autosa_cmac_csb_responder_pkg.sv
// Shared definitions for the CMAC-side CSB responder: request/response
// packet field positions, state encoding and the response packer.
package autosa_cmac_csb_responder_pkg;

    localparam int unsigned REQ_PD_W        = 63;
    localparam int unsigned REQ_ADDR_LSB    = 0;
    localparam int unsigned REQ_ADDR_W      = 22;
    localparam int unsigned REQ_WDAT_LSB    = 22;
    localparam int unsigned REQ_WRITE_BIT   = 54;
    localparam int unsigned REQ_NPOSTED_BIT = 55;

    localparam int unsigned RESP_PD_W = 34;
    localparam int unsigned RESP_TYPE = 33;
    localparam int unsigned RESP_ERR  = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } csb_state_e;

    // Response data is zero for writes and for any errored access.
    function automatic logic [RESP_PD_W-1:0] make_resp(
        input logic        is_write,
        input logic        err,
        input logic [31:0] rdat
    );
        logic [RESP_PD_W-1:0] pd;
        pd            = '0;
        pd[RESP_TYPE] = is_write;
        pd[RESP_ERR]  = err;
        pd[31:0]      = (is_write || err) ? 32'h0 : rdat;
        return pd;
    endfunction

endpackage

// File: rtl/autosa_cmac_csb_responder.sv
// CSB slave at the CMAC end of csb2cmac: decodes one request at a time into
// a single register-file access and returns a response strobe when required.
module autosa_cmac_csb_responder
    import autosa_cmac_csb_responder_pkg::*;
#(
    parameter logic [21:0] BASE_ADDR = 22'h001C00,
    parameter int unsigned OFFS_W    = 8,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic              autosa_core_clk,
    input  logic              autosa_core_rst,
    input  logic              csb2cmac_req_pvld,
    output logic              csb2cmac_req_prdy,
    input  logic [62:0]       csb2cmac_req_pd,
    output logic              cmac2csb_resp_valid,
    output logic [33:0]       cmac2csb_resp_pd,
    output logic              reg_req_vld,
    output logic              reg_req_wr,
    output logic [OFFS_W-1:0] reg_req_offs,
    output logic [31:0]       reg_req_wdat,
    input  logic              reg_ack,
    input  logic [31:0]       reg_rdat,
    input  logic              reg_err
);

    localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    csb_state_e             state_q, state_d;
    logic                   reg_req_vld_q, reg_req_vld_d;
    logic                   reg_req_wr_q, reg_req_wr_d;
    logic [OFFS_W-1:0]      reg_req_offs_q, reg_req_offs_d;
    logic [31:0]            reg_req_wdat_q, reg_req_wdat_d;
    logic                   needs_resp_q, needs_resp_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   resp_valid_q, resp_valid_d;
    logic [RESP_PD_W-1:0]   resp_pd_q, resp_pd_d;

    logic [REQ_ADDR_W-1:0]  req_addr;
    logic [31:0]            req_wdat;
    logic                   req_write;
    logic                   req_needs_resp;
    logic                   req_in_range;
    logic                   unused_pd_bits;

    assign req_addr       = csb2cmac_req_pd[REQ_ADDR_LSB +: REQ_ADDR_W];
    assign req_wdat       = csb2cmac_req_pd[REQ_WDAT_LSB +: 32];
    assign req_write      = csb2cmac_req_pd[REQ_WRITE_BIT];
    assign req_needs_resp = !req_write || csb2cmac_req_pd[REQ_NPOSTED_BIT];
    assign req_in_range   = (req_addr[21:OFFS_W] == BASE_ADDR[21:OFFS_W]);
    assign unused_pd_bits = ^csb2cmac_req_pd[62:56];

    // State and registered outputs; reset aborts any transaction in flight.
    always_ff @(posedge autosa_core_clk or posedge autosa_core_rst) begin
        if (autosa_core_rst) begin
            state_q        <= ST_IDLE;
            reg_req_vld_q  <= 1'b0;
            reg_req_wr_q   <= 1'b0;
            reg_req_offs_q <= '0;
            reg_req_wdat_q <= '0;
            needs_resp_q   <= 1'b0;
            cnt_q          <= '0;
            resp_valid_q   <= 1'b0;
            resp_pd_q      <= '0;
        end else begin
            state_q        <= state_d;
            reg_req_vld_q  <= reg_req_vld_d;
            reg_req_wr_q   <= reg_req_wr_d;
            reg_req_offs_q <= reg_req_offs_d;
            reg_req_wdat_q <= reg_req_wdat_d;
            needs_resp_q   <= needs_resp_d;
            cnt_q          <= cnt_d;
            resp_valid_q   <= resp_valid_d;
            resp_pd_q      <= resp_pd_d;
        end
    end

    // Next-state and next-value logic for request capture, access and timeout.
    always_comb begin
        state_d        = state_q;
        reg_req_vld_d  = reg_req_vld_q;
        reg_req_wr_d   = reg_req_wr_q;
        reg_req_offs_d = reg_req_offs_q;
        reg_req_wdat_d = reg_req_wdat_q;
        needs_resp_d   = needs_resp_q;
        cnt_d          = cnt_q;
        resp_valid_d   = 1'b0;
        resp_pd_d      = resp_pd_q;
        unique case (state_q)
            ST_IDLE: begin
                if (csb2cmac_req_pvld) begin
                    if (req_in_range) begin
                        state_d        = ST_ACCESS;
                        reg_req_vld_d  = 1'b1;
                        reg_req_wr_d   = req_write;
                        reg_req_offs_d = req_addr[OFFS_W-1:0];
                        reg_req_wdat_d = req_wdat;
                        needs_resp_d   = req_needs_resp;
                        cnt_d          = '0;
                    end else if (req_needs_resp) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_pd_d    = make_resp(req_write, 1'b1, 32'h0);
                    end
                end
            end
            ST_ACCESS: begin
                // An ack in the final allowed cycle wins over the timeout.
                if (reg_ack) begin
                    reg_req_vld_d = 1'b0;
                    state_d       = needs_resp_q ? ST_RESP : ST_IDLE;
                    resp_valid_d  = needs_resp_q;
                    resp_pd_d     = make_resp(reg_req_wr_q, reg_err, reg_rdat);
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    reg_req_vld_d = 1'b0;
                    state_d       = needs_resp_q ? ST_RESP : ST_IDLE;
                    resp_valid_d  = needs_resp_q;
                    resp_pd_d     = make_resp(reg_req_wr_q, 1'b1, 32'h0);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode; only prdy is combinational from the state register.
    always_comb begin
        csb2cmac_req_prdy   = (state_q == ST_IDLE);
        cmac2csb_resp_valid = resp_valid_q;
        cmac2csb_resp_pd    = resp_pd_q;
        reg_req_vld         = reg_req_vld_q;
        reg_req_wr          = reg_req_wr_q;
        reg_req_offs        = reg_req_offs_q;
        reg_req_wdat        = reg_req_wdat_q;
    end

endmodule

// File: tb/tb_autosa_cmac_csb_responder.sv
// Directed bench for autosa_cmac_csb_responder. Each transaction is turned
// into per-cycle expectations from the transaction-level timing rules; a
// negedge process compares the DUT against them every cycle.
module tb_autosa_cmac_csb_responder;

    localparam int          TMO  = 4;
    localparam logic [21:0] BASE = 22'h001C00;
    localparam int          NCYC = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pvld = 1'b0;
    logic        prdy;
    logic [62:0] req_pd = '0;
    logic        resp_valid;
    logic [33:0] resp_pd;
    logic        vld;
    logic        wr;
    logic [7:0]  offs;
    logic [31:0] wdat;
    logic        ack = 1'b0;
    logic [31:0] rdat = '0;
    logic        err = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    bit          exp_prdy [NCYC];
    bit          exp_vld  [NCYC];
    bit          exp_wr   [NCYC];
    logic [7:0]  exp_offs [NCYC];
    logic [31:0] exp_wdat [NCYC];
    bit          exp_rv   [NCYC];
    logic [33:0] exp_pd   [NCYC];

    autosa_cmac_csb_responder #(
        .BASE_ADDR (BASE),
        .OFFS_W    (8),
        .TIMEOUT   (TMO)
    ) dut (
        .autosa_core_clk     (clk),
        .autosa_core_rst     (rst),
        .csb2cmac_req_pvld   (pvld),
        .csb2cmac_req_prdy   (prdy),
        .csb2cmac_req_pd     (req_pd),
        .cmac2csb_resp_valid (resp_valid),
        .cmac2csb_resp_pd    (resp_pd),
        .reg_req_vld         (vld),
        .reg_req_wr          (wr),
        .reg_req_offs        (offs),
        .reg_req_wdat        (wdat),
        .reg_ack             (ack),
        .reg_rdat            (rdat),
        .reg_err             (err)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Per-cycle comparison against the expectation tables.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("prdy", 64'(prdy), 64'(exp_prdy[cyc]));
            chk("resp_valid", 64'(resp_valid), 64'(exp_rv[cyc]));
            chk("reg_req_vld", 64'(vld), 64'(exp_vld[cyc]));
            if (exp_rv[cyc]) chk("resp_pd", 64'(resp_pd), 64'(exp_pd[cyc]));
            if (exp_vld[cyc]) begin
                chk("reg_req_wr", 64'(wr), 64'(exp_wr[cyc]));
                chk("reg_req_offs", 64'(offs), 64'(exp_offs[cyc]));
                if (exp_wr[cyc]) chk("reg_req_wdat", 64'(wdat), 64'(exp_wdat[cyc]));
            end
        end
    end

    // One request. k = cycle (1-based, counted from the first reg_req_vld
    // cycle) in which reg_ack is driven; 0 = never. lit_en pins the response
    // packet to a hand-computed value.
    task automatic do_req(input logic [21:0] addr, input logic [31:0] wd, input logic w,
                          input logic np, input int k, input logic [31:0] rd, input logic er,
                          input logic lit_en, input logic [33:0] lit_pd);
        bit inr, nr, tmo;
        int kend, t, last, resp_at;
        inr  = (addr[21:8] == BASE[21:8]);
        nr   = !w || np;
        tmo  = (k == 0) || (k > TMO);
        kend = tmo ? TMO : k;
        pvld   = 1'b1;
        req_pd = {7'h7F, np, w, wd, addr};
        tick();
        pvld   = 1'b0;
        req_pd = '0;
        t = cyc;
        resp_at = -1;
        if (!inr) begin
            if (nr) begin
                exp_prdy[t] = 1'b0;
                exp_rv[t]   = 1'b1;
                exp_pd[t]   = {w, 1'b1, 32'h0};
                resp_at     = 0;
            end
            last = nr ? 2 : 0;
        end else begin
            for (int i = 0; i < kend; i++) begin
                exp_vld[t+i]  = 1'b1;
                exp_prdy[t+i] = 1'b0;
                exp_wr[t+i]   = w;
                exp_offs[t+i] = addr[7:0];
                exp_wdat[t+i] = wd;
            end
            if (nr) begin
                exp_prdy[t+kend] = 1'b0;
                exp_rv[t+kend]   = 1'b1;
                exp_pd[t+kend]   = {w, tmo | er, (w | tmo | er) ? 32'h0 : rd};
                resp_at          = kend;
            end
            last = (k > kend + 1) ? k : kend + 1;
        end
        for (int j = 0; j < last; j++) begin
            if (inr && k != 0 && j == k - 1) begin
                ack = 1'b1; rdat = rd; err = er;
            end else begin
                ack = 1'b0; rdat = $urandom; err = 1'b0;
            end
            if (lit_en && j == resp_at)
                chk("literal_resp", {30'h0, resp_valid, resp_pd}, {30'h0, 1'b1, lit_pd});
            tick();
        end
        ack = 1'b0; err = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NCYC; i++) begin
            exp_prdy[i] = 1'b1; exp_vld[i] = 1'b0; exp_rv[i] = 1'b0;
            exp_wr[i] = 1'b0; exp_offs[i] = '0; exp_wdat[i] = '0; exp_pd[i] = '0;
        end
        #1;
        @(posedge clk);
        #1;
        chk("rst_prdy", 64'(prdy), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_pd", 64'(resp_pd), 64'd0);
        chk("rst_vld", 64'(vld), 64'd0);
        chk("rst_wr", 64'(wr), 64'd0);
        chk("rst_offs", 64'(offs), 64'd0);
        chk("rst_wdat", 64'(wdat), 64'd0);
        rst = 1'b0;
        chk_en = 1'b1;
        tick();

        do_req(22'h001C05, 32'h0, 1'b0, 1'b0, 1, 32'hDEADBEEF, 1'b0, 1'b1, 34'h0DEADBEEF);
        do_req(22'h001CFF, 32'h12345678, 1'b1, 1'b1, 3, 32'h0, 1'b0, 1'b1, 34'h200000000);
        do_req(22'h001C10, 32'hCAFEF00D, 1'b1, 1'b0, 2, 32'h0, 1'b0, 1'b0, 34'h0);
        do_req(22'h002000, 32'h0, 1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b1, 34'h100000000);
        do_req(22'h001C40, 32'h0, 1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b1, 34'h100000000);
        do_req(22'h001C41, 32'h0, 1'b0, 1'b0, 6, 32'h55555555, 1'b0, 1'b1, 34'h100000000);
        do_req(22'h001C20, 32'h0, 1'b0, 1'b0, 2, 32'hAAAA0000, 1'b1, 1'b1, 34'h100000000);
        do_req(22'h001C21, 32'h0F0F0F0F, 1'b1, 1'b1, 1, 32'h0, 1'b1, 1'b1, 34'h300000000);
        do_req(22'h001C00, 32'h0, 1'b0, 1'b0, 4, 32'h00001234, 1'b0, 1'b1, 34'h000001234);
        do_req(22'h001C22, 32'h11112222, 1'b1, 1'b0, 0, 32'h0, 1'b0, 1'b0, 34'h0);
        do_req(22'h3FFC00, 32'h1, 1'b1, 1'b0, 0, 32'h0, 1'b0, 1'b0, 34'h0);
        do_req(22'h000C00, 32'h2, 1'b1, 1'b0, 0, 32'h0, 1'b0, 1'b0, 34'h0);
        do_req(22'h001BFF, 32'h3, 1'b1, 1'b1, 0, 32'h0, 1'b0, 1'b1, 34'h300000000);
        do_req(22'h001BFF, 32'h0, 1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b1, 34'h100000000);
        tick();

        // Reset during an access: vld must drop at once and no response follow.
        pvld   = 1'b1;
        req_pd = {7'h00, 1'b0, 1'b0, 32'h0, 22'h001C33};
        tick();
        pvld   = 1'b0;
        req_pd = '0;
        chk("pre_rst_vld", 64'(vld), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_vld", 64'(vld), 64'd0);
        chk("async_rst_prdy", 64'(prdy), 64'd1);
        chk("async_rst_resp_valid", 64'(resp_valid), 64'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        cyc++;
        for (int i = 0; i < 8; i++) tick();

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/autosa_cmac_csb_responder.md
# autosa_cmac_csb_responder

CSB slave endpoint at the CMAC end of the csb2cmac link. It sits downstream of the csb2cmac retiming stage and accepts 63-bit request packets with a valid/ready handshake. It decodes each request into a single access on a local register-file port, then returns a 34-bit response packet with a valid strobe only. It handles posted and non-posted writes, out-of-range addresses and unresponsive register logic (timeout).

## Interface
Parameters:
- BASE_ADDR, 22'h001C00, word-address base of the CMAC register window
- OFFS_W, 8, width of the in-window word offset; window = 2^OFFS_W words
- TIMEOUT, 255, maximum cycles to wait for reg_ack; 0 disables the timeout

Ports:
- autosa_core_clk  in  1  core clock; single clock domain
- autosa_core_rst  in  1  asynchronous reset, active-high
- csb2cmac_req_pvld  in  1  request valid
- csb2cmac_req_prdy  out  1  request ready
- csb2cmac_req_pd  in  63  request packet
- cmac2csb_resp_valid  out  1  response strobe; no backpressure
- cmac2csb_resp_pd  out  34  response packet
- reg_req_vld  out  1  register access request
- reg_req_wr  out  1  1 = write, 0 = read
- reg_req_offs  out  OFFS_W  word offset within the window
- reg_req_wdat  out  32  write data
- reg_ack  in  1  access complete; sampled only while reg_req_vld=1
- reg_rdat  in  32  read data, valid when reg_ack=1
- reg_err  in  1  access error, valid when reg_ack=1

## Operation
Request fields:
- addr = pd[21:0]
- wdat = pd[53:22]
- write = pd[54]
- nposted = pd[55]
- pd[62:56] is ignored

Response packet:
- bit 33 = 0 for a read response, 1 for a write response
- bit 32 = error
- bits 31:0 = read data; 0 for writes and for any error

in_range = (addr[21:OFFS_W] == BASE_ADDR[21:OFFS_W]).

needs_resp = !write | nposted. A posted write never produces a response.

State machine:
- IDLE: prdy = 1. On pvld&prdy, capture the request.
  - in_range → ACCESS.
  - !in_range and needs_resp → RESP with error = 1.
  - !in_range and posted write → stay IDLE; the request is dropped.
- ACCESS: reg_req_vld = 1; reg_req_* are held stable from the captured request. The timeout counter increments each cycle.
  - reg_ack → capture {reg_err, reg_rdat}. Go to RESP if needs_resp, else IDLE.
  - No ack and counter == TIMEOUT-1 (TIMEOUT ≠ 0) → deassert reg_req_vld, set error = 1 and rdat = 0. Go to RESP if needs_resp, else IDLE.
- RESP: resp_valid = 1 for exactly one cycle, then → IDLE.

Additional rules:
- Read data is forced to 0 whenever error = 1.
- Only one transaction is outstanding at a time; prdy = 0 in ACCESS and RESP.
- A late reg_ack arriving after a timeout, or while reg_req_vld = 0, is ignored.

## Timing
Let request acceptance occur at edge t.
- In-range access: reg_req_vld is high from cycle t+1. If reg_ack arrives in cycle t+k, resp_valid is high in cycle t+k+1 and prdy returns high in cycle t+k+2.
- Best case is k = 1: response 2 cycles after acceptance, next acceptance 3 cycles after.
- Out-of-range with response: resp_valid in t+1, prdy in t+2.
- Out-of-range posted write: prdy stays high; back-to-back acceptance is allowed.
- Timeout: if no ack arrives, reg_req_vld stays high for exactly TIMEOUT cycles (t+1 … t+TIMEOUT). The error response follows in t+TIMEOUT+1.
- All outputs except prdy are registered. prdy is decoded from the state register.
- Reset values: state IDLE, prdy = 1, resp_valid = 0, resp_pd = 0, reg_req_vld = 0, reg_req_wr = 0, reg_req_offs = 0, reg_req_wdat = 0, counter = 0.
- Reset asserted mid-transaction aborts it immediately. No response is emitted afterwards, and reg_req_vld drops asynchronously.

## Structure
- Shared package holds:
  - CSB request field bit positions
  - response bit positions: RESP_TYPE = 33, RESP_ERR = 32
  - state encoding: IDLE, ACCESS, RESP
- Single flat module; no sub-module is needed.
- The timeout counter is $clog2(TIMEOUT+1) bits wide, minimum 1.

## Test plan
- Read at addr 22'h001C05; reg_ack with rdat 32'hDEADBEEF and err = 0 on the first reg_req_vld cycle → reg_req_offs = 8'h05, then resp_pd = 34'h0DEADBEEF exactly 2 cycles after acceptance.
- Non-posted write at addr 22'h001CFF with wdat 32'h12345678; ack after 3 cycles → reg_req_wr = 1 and wdat driven; resp_pd = 34'h200000000.
- Posted write in range → one register access occurs and no resp_valid ever; prdy returns the cycle after the ack.
- Read at addr 22'h002000 (out of range) → no reg_req_vld; resp_pd = 34'h100000000 in t+1.
- TIMEOUT = 4 and reg_ack held low on a read → reg_req_vld high for 4 cycles, then resp_pd = 34'h100000000; a late ack is ignored.
- Reset pulsed during ACCESS → reg_req_vld = 0 immediately, prdy = 1 after release, and no spurious response.
